// File: rtl/serial_subtractor_pkg.sv
// Shared definitions for the bit-serial subtractor: state encoding and sizing helpers.
// The state values are the fixed 2-bit binary encoding used by every controller of this block.
package serial_subtractor_pkg;

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_SHIFT = 2'd1;
    localparam logic [1:0] S_DONE  = 2'd2;

    typedef enum logic [1:0] {
        StIdle  = S_IDLE,
        StShift = S_SHIFT,
        StDone  = S_DONE
    } state_e;

    // One extra bit so the counter can reach WIDTH without wrapping.
    function automatic int unsigned cnt_width(input int unsigned w);
        return $clog2(w) + 1;
    endfunction

endpackage

// File: rtl/full_subtractor.sv
// One-bit full subtractor: D = A - B - Bin, Bout set when the bit position underflows.
module full_subtractor (
    input  logic A,
    input  logic B,
    input  logic Bin,
    output logic D,
    output logic Bout
);

    always_comb begin
        D    = A ^ B ^ Bin;
        Bout = (~A & B) | (~(A ^ B) & Bin);
    end

endmodule

// File: rtl/serial_subtractor.sv
// Bit-serial WIDTH-bit subtractor, LSB first, one bit per clock, Start/Busy/Done handshake.
// Diff/Borrow are registered and only change on the final shift edge or on reset.
module serial_subtractor
    import serial_subtractor_pkg::*;
#(
    parameter int unsigned WIDTH = 4
) (
    input  logic             Clk,
    input  logic             Rst_n,
    input  logic             Start,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    output logic [WIDTH-1:0] Diff,
    output logic             Borrow,
    output logic             Busy,
    output logic             Done
);

    localparam int unsigned CW = cnt_width(WIDTH);
    localparam int unsigned DW = WIDTH - 1;
    localparam logic [CW-1:0] LastBit = CW'(WIDTH - 1);

    state_e          state;
    logic [WIDTH-1:0] a_sr;
    logic [WIDTH-1:0] b_sr;
    // Holds the WIDTH-1 result bits produced before the final one.
    logic [DW-1:0]   d_sr;
    logic            borrow_ff;
    logic [CW-1:0]   cnt;

    logic d_bit;
    logic bo_bit;

    full_subtractor u_full_subtractor (
        .A    (a_sr[0]),
        .B    (b_sr[0]),
        .Bin  (borrow_ff),
        .D    (d_bit),
        .Bout (bo_bit)
    );

    always_ff @(posedge Clk or negedge Rst_n) begin
        if (!Rst_n) begin
            state     <= StIdle;
            a_sr      <= '0;
            b_sr      <= '0;
            d_sr      <= '0;
            borrow_ff <= 1'b0;
            cnt       <= '0;
            Diff      <= '0;
            Borrow    <= 1'b0;
            Busy      <= 1'b0;
            Done      <= 1'b0;
        end else begin
            unique case (state)
                StIdle: begin
                    if (Start) begin
                        a_sr      <= A;
                        b_sr      <= B;
                        borrow_ff <= 1'b0;
                        cnt       <= '0;
                        Busy      <= 1'b1;
                        state     <= StShift;
                    end
                end

                StShift: begin
                    a_sr      <= a_sr >> 1;
                    b_sr      <= b_sr >> 1;
                    d_sr      <= DW'({d_bit, d_sr} >> 1);
                    borrow_ff <= bo_bit;
                    cnt       <= cnt + CW'(1);
                    if (cnt == LastBit) begin
                        Diff   <= {d_bit, d_sr};
                        Borrow <= bo_bit;
                        Busy   <= 1'b0;
                        Done   <= 1'b1;
                        state  <= StDone;
                    end
                end

                StDone: begin
                    Done <= 1'b0;
                    // A Start seen here launches the next operation back-to-back.
                    if (Start) begin
                        a_sr      <= A;
                        b_sr      <= B;
                        borrow_ff <= 1'b0;
                        cnt       <= '0;
                        Busy      <= 1'b1;
                        state     <= StShift;
                    end else begin
                        state <= StIdle;
                    end
                end

                default: begin
                    state <= StIdle;
                    Busy  <= 1'b0;
                    Done  <= 1'b0;
                end
            endcase
        end
    end

endmodule
